// File: rtl/f2i_fsm_if.sv
// Handshake bundle between the divider result stage and the float-to-int converter.
// The master drives the operand and strobe; the slave returns the result, done pulse and status.
interface f2i_fsm_if;
   logic [31:0] f;
   logic        r_i;
   logic [31:0] q;
   logic        r_o;
   logic        busy;
   logic        ovf;

   modport master (
      output f, r_i,
      input  q, r_o, busy, ovf
   );

   modport slave (
      input  f, r_i,
      output q, r_o, busy, ovf
   );
endinterface

// File: rtl/f2i_fsm.sv
// Multi-cycle IEEE-754 single to 32-bit signed integer converter, one bit of shift per cycle.
// Define F2I_ROUND_EN for round-to-nearest-even; by default the result truncates toward zero.
module f2i_fsm (
   input  logic     clk,
   input  logic     rst,
   f2i_fsm_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE,
      CLASS,
      SHIFT,
      SIGN,
      DONE
   } state_t;

`ifdef F2I_ROUND_EN
   localparam logic [7:0] MIN_E = 8'd126;
`else
   localparam logic [7:0] MIN_E = 8'd127;
`endif
   // Exponent at which the mantissa LSB has weight 1; k is always below 32, so 5-bit math suffices.
   localparam logic [7:0] UNIT_E  = 8'd150;
   localparam logic [4:0] UNIT_LO = UNIT_E[4:0];
   localparam logic [7:0] SAT_E   = 8'd158;
   localparam logic [31:0] INT_MAX = 32'h7FFF_FFFF;
   localparam logic [31:0] INT_MIN = 32'h8000_0000;

   state_t      state_q, state_d;
   logic        s_q, s_d;
   logic [7:0]  e_q, e_d;
   logic [31:0] mag_q, mag_d;
   logic [4:0]  k_q, k_d;
   logic        left_q, left_d;
   logic        bypass_q, bypass_d;
   logic        ovf_pend_q, ovf_pend_d;
   logic [31:0] q_q, q_d;
   logic        ovf_q, ovf_d;
   logic        r_o_q, r_o_d;
   logic [31:0] mag_rnd;
`ifdef F2I_ROUND_EN
   logic        guard_q, guard_d;
   logic        sticky_q, sticky_d;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         s_q        <= 1'b0;
         e_q        <= 8'd0;
         mag_q      <= 32'd0;
         k_q        <= 5'd0;
         left_q     <= 1'b0;
         bypass_q   <= 1'b0;
         ovf_pend_q <= 1'b0;
         q_q        <= 32'd0;
         ovf_q      <= 1'b0;
         r_o_q      <= 1'b0;
`ifdef F2I_ROUND_EN
         guard_q    <= 1'b0;
         sticky_q   <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         s_q        <= s_d;
         e_q        <= e_d;
         mag_q      <= mag_d;
         k_q        <= k_d;
         left_q     <= left_d;
         bypass_q   <= bypass_d;
         ovf_pend_q <= ovf_pend_d;
         q_q        <= q_d;
         ovf_q      <= ovf_d;
         r_o_q      <= r_o_d;
`ifdef F2I_ROUND_EN
         guard_q    <= guard_d;
         sticky_q   <= sticky_d;
`endif
      end
   end

   always_comb begin
      state_d    = state_q;
      s_d        = s_q;
      e_d        = e_q;
      mag_d      = mag_q;
      k_d        = k_q;
      left_d     = left_q;
      bypass_d   = bypass_q;
      ovf_pend_d = ovf_pend_q;
      q_d        = q_q;
      ovf_d      = ovf_q;
      r_o_d      = 1'b0;
      mag_rnd    = mag_q;
`ifdef F2I_ROUND_EN
      guard_d    = guard_q;
      sticky_d   = sticky_q;
`endif

      case (state_q)
         IDLE: begin
            if (bus.r_i) begin
               s_d        = bus.f[31];
               e_d        = bus.f[30:23];
               mag_d      = {8'h00, 1'b1, bus.f[22:0]};
               k_d        = 5'd0;
               left_d     = 1'b0;
               bypass_d   = 1'b0;
               ovf_pend_d = 1'b0;
`ifdef F2I_ROUND_EN
               guard_d    = 1'b0;
               sticky_d   = 1'b0;
`endif
               state_d    = CLASS;
            end
         end

         CLASS: begin
            if (e_q >= SAT_E) begin
               // Only exactly -2^31 is representable; everything else here saturates.
               bypass_d   = 1'b1;
               mag_d      = s_q ? INT_MIN : INT_MAX;
               ovf_pend_d = !(s_q && (e_q == SAT_E) && (mag_q[22:0] == 23'd0));
               state_d    = SIGN;
            end else if (e_q < MIN_E) begin
               mag_d   = 32'd0;
               state_d = SIGN;
            end else if (e_q > UNIT_E) begin
               k_d     = e_q[4:0] - UNIT_LO;
               left_d  = 1'b1;
               state_d = SHIFT;
            end else begin
               k_d     = UNIT_LO - e_q[4:0];
               left_d  = 1'b0;
               state_d = (e_q == UNIT_E) ? SIGN : SHIFT;
            end
         end

         SHIFT: begin
            if (left_q) begin
               mag_d = {mag_q[30:0], 1'b0};
            end else begin
               mag_d = {1'b0, mag_q[31:1]};
`ifdef F2I_ROUND_EN
               guard_d  = mag_q[0];
               sticky_d = sticky_q | guard_q;
`endif
            end
            k_d = k_q - 5'd1;
            if (k_q == 5'd1) begin
               state_d = SIGN;
            end
         end

         SIGN: begin
`ifdef F2I_ROUND_EN
            mag_rnd = mag_q + {31'd0, guard_q & (sticky_q | mag_q[0])};
`endif
            if (bypass_q) begin
               q_d = mag_q;
            end else begin
               q_d = s_q ? (32'd0 - mag_rnd) : mag_rnd;
            end
            ovf_d   = ovf_pend_q;
            r_o_d   = 1'b1;
            state_d = DONE;
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bus.q    = q_q;
   assign bus.r_o  = r_o_q;
   assign bus.ovf  = ovf_q;
   assign bus.busy = (state_q != IDLE);

endmodule

// File: doc/f2i_fsm.md
F2I_FSM -- requirements
Module: f2i_fsm

Interface
REQ-001 Parameters: none; all widths fixed at 32-bit IEEE-754 single in, 32-bit two's-complement out.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 f  input  32  float operand, the result word of the upstream divider stage; sampled only on accept.
REQ-005 r_i  input  1  operand-valid strobe (driven by divider r_o); accepted only in IDLE.
REQ-006 q  output  32  signed integer result, registered, held until next completion.
REQ-007 r_o  output  1  registered one-cycle done pulse; q/ovf valid while high and after.
REQ-008 busy  output  1  high whenever state != IDLE.
REQ-009 ovf  output  1  registered; set with q when input saturated (NaN, Inf, out of range).

Function
REQ-010 States: IDLE, CLASS, SHIFT, SIGN, DONE; DONE always returns to IDLE on next edge.
REQ-011 IDLE and r_i=1: latch s=f[31], e=f[30:23], m={1,f[22:0]}; go CLASS. r_i=0: stay.
REQ-012 r_i in any non-IDLE state is ignored; no queuing.
REQ-013 CLASS, e==0 or e<127: magnitude 0, ovf=0, go SIGN.
REQ-014 CLASS, s=1, e==158, f[22:0]==0: result 0x80000000, ovf=0, go SIGN (negation bypassed).
REQ-015 CLASS, otherwise e>=158 (incl. 255): result 0x7FFFFFFF if s=0 else 0x80000000, ovf=1, go SIGN (negation bypassed).
REQ-016 CLASS, 127<=e<=157: k=|e-150|, direction left if e>150 else right; k=0 goes SIGN, else SHIFT.
REQ-017 SHIFT: one 1-bit shift of 32-bit magnitude per cycle, k decremented; k reaching 0 goes SIGN.
REQ-018 Right shifts truncate toward zero (absent REQ-027 macro).
REQ-019 SIGN: q_next = s ? -mag : mag for normal paths; go DONE.
REQ-020 DONE entry edge: q, ovf updated; r_o=1 exactly one cycle.
REQ-021 Latency: r_o high k+2 edges after accept edge; k=0 for zero/saturate paths; max 25.
REQ-022 Back-to-back: new r_i accepted at earliest in cycle after r_o pulse (IDLE).
REQ-023 -0.0 (0x80000000 float) returns q=0, ovf=0.

Reset
REQ-024 rst asserted: state=IDLE, q=0, r_o=0, busy=0, ovf=0, internal regs 0, immediately without clk.
REQ-025 rst mid-operation aborts; no r_o pulse follows; q stays 0.
REQ-026 First accept possible on first rising edge after rst deasserts.

Configuration
REQ-027 Macro F2I_ROUND_EN defined: round-to-nearest-even; SHIFT tracks guard and sticky bits; SIGN adds round increment to magnitude before negation; e==126 taken via SHIFT path (k=24, right), max latency 26.
REQ-028 F2I_ROUND_EN undefined: truncation only, guard/sticky logic absent, e==126 yields 0 via REQ-013.

Verification
REQ-029 f=0x3F800000 (1.0), r_i pulse -> q=0x00000001, ovf=0, r_o high 25 edges after accept.
REQ-030 f=0xC0B80000 (-5.75) -> q=0xFFFFFFFB; with F2I_ROUND_EN q=0xFFFFFFFA; f=0x3FC00000 (1.5) -> 1 / 2 with macro; f=0x3F000000 (0.5) -> 0 both.
REQ-031 f=0x4F000000 -> q=0x7FFFFFFF, ovf=1, latency 2; f=0xCF000000 -> q=0x80000000, ovf=0; f=0x7FC00000 -> q=0x7FFFFFFF, ovf=1.
REQ-032 f=0x42C80000 (100.0) with second r_i pulse while busy -> single r_o, q=0x00000064; ignored operand never processed.
REQ-033 Accept 0x3F800000, assert rst on 5th SHIFT cycle -> q=0, r_o never pulses, busy=0 immediately.
REQ-034 Chained with divider: n=0x41200000, x=0x40000000 (10/2) -> q=0x00000005 one f2i pass after divider r_o.
